// File: rtl/cache_victim_writeback.sv
// cache_victim_writeback
// Single-entry victim writeback buffer. The block accepts one dirty victim line
// through a valid/ready handshake. It then writes that line to the bus as
// BEATS beats, advancing by one beat for each BusBeatAck. While the line is
// held, the block flags cache lookups that fall in the buffered line.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   EvictValid/Ready      victim line handshake (Ready is high only in IDLE)
//   EvictAdr, EvictLine   victim line address (offset ignored) and data
//   BusWrite              beat request valid
//   BusAdr, BusWData      byte address and data of the current beat
//   BusLast               current beat is the final one of the line
//   BusBeatAck            bus accepted the current beat
//   LookupAdr, LookupHit  snoop address and same-line hit while occupied
//   Busy                  buffer occupied
module cache_victim_writeback #(
  parameter int unsigned PA_BITS = 32,
  parameter int unsigned LINELEN = 512,
  parameter int unsigned BEATLEN = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               EvictValid,
  output logic               EvictReady,
  input  logic [PA_BITS-1:0] EvictAdr,
  input  logic [LINELEN-1:0] EvictLine,
  output logic               BusWrite,
  output logic [PA_BITS-1:0] BusAdr,
  output logic [BEATLEN-1:0] BusWData,
  output logic               BusLast,
  input  logic               BusBeatAck,
  input  logic [PA_BITS-1:0] LookupAdr,
  output logic               LookupHit,
  output logic               Busy
);

  localparam int unsigned BEATS      = LINELEN / BEATLEN;
  localparam int unsigned OFFLEN     = $clog2(LINELEN / 8);
  localparam int unsigned CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned BEAT_SHIFT = $clog2(BEATLEN / 8);
  localparam logic [PA_BITS-1:0] OFF_MASK  = PA_BITS'((64'd1 << OFFLEN) - 64'd1);
  localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t                           state;
  logic [CNT_W-1:0]                 beatCnt;
  logic [PA_BITS-1:0]               lineAdr;
  logic [BEATS-1:0][BEATLEN-1:0]    lineData;
  logic                             capture;
  logic                             lastBeat;

  assign capture  = (state == IDLE) && EvictValid;
  assign lastBeat = (beatCnt == LAST_BEAT);

  // Control FSM: capture in IDLE, one beat per ack in WRITE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      beatCnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (EvictValid) begin
            state   <= WRITE;
            beatCnt <= '0;
          end
        end
        WRITE: begin
          if (BusBeatAck) begin
            if (lastBeat) begin
              state   <= IDLE;
              beatCnt <= '0;
            end else begin
              beatCnt <= beatCnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state   <= IDLE;
          beatCnt <= '0;
        end
      endcase
    end
  end

  // Line storage; the offset is cleared so beat addresses never carry out of the line
  always_ff @(posedge clk) begin
    if (capture) begin
      lineAdr  <= EvictAdr & ~OFF_MASK;
      lineData <= EvictLine;
    end
  end

  // Outputs decode registered state only; bus payload is zero when idle
  assign Busy       = (state == WRITE);
  assign BusWrite   = (state == WRITE);
  assign EvictReady = (state == IDLE);
  assign BusAdr     = Busy ? (lineAdr + (PA_BITS'(beatCnt) << BEAT_SHIFT)) : '0;
  assign BusWData   = Busy ? lineData[beatCnt] : '0;
  assign BusLast    = Busy & lastBeat;

  // Same-line snoop so the cache can stall refills of the line being written back
  assign LookupHit  = Busy & ((LookupAdr & ~OFF_MASK) == lineAdr);

endmodule

// File: tb/tb_cache_victim_writeback.sv
// Testbench for cache_victim_writeback: table-driven directed vectors,
// hand-written multi-cycle sequences, and randomized traffic checked against
// a queue-of-beats reference model.
module tb_cache_victim_writeback;

  localparam int unsigned PA = 32;
  localparam int unsigned LL = 512;
  localparam int unsigned BL = 64;
  localparam int unsigned NB = LL / BL;
  localparam logic [31:0] OFF = 32'h0000_003F;

  logic          clk = 1'b0;
  logic          reset;
  logic          EvictValid;
  logic          EvictReady;
  logic [PA-1:0] EvictAdr;
  logic [LL-1:0] EvictLine;
  logic          BusWrite;
  logic [PA-1:0] BusAdr;
  logic [BL-1:0] BusWData;
  logic          BusLast;
  logic          BusBeatAck;
  logic [PA-1:0] LookupAdr;
  logic          LookupHit;
  logic          Busy;

  always #5 clk = ~clk;

  cache_victim_writeback #(.PA_BITS(PA), .LINELEN(LL), .BEATLEN(BL)) dut (
    .clk(clk), .reset(reset),
    .EvictValid(EvictValid), .EvictReady(EvictReady),
    .EvictAdr(EvictAdr), .EvictLine(EvictLine),
    .BusWrite(BusWrite), .BusAdr(BusAdr), .BusWData(BusWData),
    .BusLast(BusLast), .BusBeatAck(BusBeatAck),
    .LookupAdr(LookupAdr), .LookupHit(LookupHit), .Busy(Busy)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] adr;
    logic [63:0] data;
    logic        last;
  } beat_t;

  // Reference model: the beats still owed to the bus, plus the held line address
  beat_t       q[$];
  logic [31:0] mLine;

  typedef struct {
    logic        valid;
    logic        ack;
    logic [31:0] lk;
    logic        eReady;
    logic        eWrite;
    logic        eLast;
    logic        eHit;
    logic [31:0] eAdr;
    logic [63:0] eData;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LL-1:0] mkLine(input logic [63:0] base);
    logic [LL-1:0] l;
    for (int i = 0; i < int'(NB); i++) l[i*64 +: 64] = base + 64'(i);
    return l;
  endfunction

  task automatic modelCheck();
    bit busy;
    busy = (q.size() != 0);
    chk("EvictReady", 64'(EvictReady), 64'(!busy));
    chk("BusWrite", 64'(BusWrite), 64'(busy));
    chk("Busy", 64'(Busy), 64'(busy));
    chk("LookupHit", 64'(LookupHit), 64'(busy && ((LookupAdr & ~OFF) == mLine)));
    if (busy) begin
      chk("BusAdr", 64'(BusAdr), 64'(q[0].adr));
      chk("BusWData", BusWData, q[0].data);
      chk("BusLast", 64'(BusLast), 64'(q[0].last));
    end
  endtask

  task automatic modelStep();
    if (q.size() != 0) begin
      if (BusBeatAck) void'(q.pop_front());
    end else if (EvictValid) begin
      mLine = EvictAdr & ~OFF;
      for (int i = 0; i < int'(NB); i++) begin
        beat_t b;
        b.adr  = mLine + 32'(i * 8);
        b.data = EvictLine[i*64 +: 64];
        b.last = (i == int'(NB) - 1);
        q.push_back(b);
      end
    end
  endtask

  // Inputs are driven just after a falling edge; check, then advance one cycle
  task automatic step();
    #1;
    modelCheck();
    modelStep();
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    EvictValid = 1'b0;
    BusBeatAck = 1'b1;
    while (q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d beats left expected 0", q.size());
    end
    BusBeatAck = 1'b0;
    step();
  endtask

  logic [31:0] obsAdr[NB];
  logic [63:0] obsData[NB];

  initial begin
    reset = 1'b0; EvictValid = 1'b0; EvictAdr = '0; EvictLine = '0;
    BusBeatAck = 1'b0; LookupAdr = '0; mLine = '0;

    // Reset state
    #1;
    chk("rst_EvictReady", 64'(EvictReady), 64'd1);
    chk("rst_BusWrite", 64'(BusWrite), 64'd0);
    chk("rst_Busy", 64'(Busy), 64'd0);
    chk("rst_LookupHit", 64'(LookupHit), 64'd0);
    chk("rst_BusAdr", 64'(BusAdr), 64'd0);
    chk("rst_BusWData", BusWData, 64'd0);
    chk("rst_BusLast", 64'(BusLast), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) step();

    // Directed vector table: full line, ack every cycle, with lookup snoops
    vt[0] = '{valid: 1'b1, ack: 1'b0, lk: 32'h8000_1200, eReady: 1'b1, eWrite: 1'b0,
              eLast: 1'b0, eHit: 1'b0, eAdr: 32'h0, eData: 64'h0};
    for (int i = 0; i < 8; i++) begin
      vt[i+1] = '{valid: 1'b0, ack: 1'b1,
                  lk: (i % 2 == 0) ? 32'h8000_123C : 32'h8000_1240,
                  eReady: 1'b0, eWrite: 1'b1, eLast: (i == 7), eHit: (i % 2 == 0),
                  eAdr: 32'h8000_1200 + 32'(8 * i),
                  eData: 64'h1111_0000_0000_0000 + 64'(i)};
    end
    vt[9]  = '{valid: 1'b0, ack: 1'b0, lk: 32'h8000_1200, eReady: 1'b1, eWrite: 1'b0,
               eLast: 1'b0, eHit: 1'b0, eAdr: 32'h0, eData: 64'h0};
    vt[10] = '{valid: 1'b0, ack: 1'b1, lk: 32'h8000_1200, eReady: 1'b1, eWrite: 1'b0,
               eLast: 1'b0, eHit: 1'b0, eAdr: 32'h0, eData: 64'h0};

    EvictAdr  = 32'h8000_1234;
    EvictLine = mkLine(64'h1111_0000_0000_0000);
    for (int k = 0; k < 11; k++) begin
      EvictValid = vt[k].valid;
      BusBeatAck = vt[k].ack;
      LookupAdr  = vt[k].lk;
      #1;
      chk($sformatf("vec%0d_ready", k), 64'(EvictReady), 64'(vt[k].eReady));
      chk($sformatf("vec%0d_write", k), 64'(BusWrite), 64'(vt[k].eWrite));
      chk($sformatf("vec%0d_hit", k), 64'(LookupHit), 64'(vt[k].eHit));
      if (vt[k].eWrite) begin
        chk($sformatf("vec%0d_adr", k), 64'(BusAdr), 64'(vt[k].eAdr));
        chk($sformatf("vec%0d_data", k), BusWData, vt[k].eData);
        chk($sformatf("vec%0d_last", k), 64'(BusLast), 64'(vt[k].eLast));
      end
      step();
    end

    // Ack stalls: one idle cycle before each beat, three before beat 4
    BusBeatAck = 1'b0;
    EvictValid = 1'b1;
    step();
    EvictValid = 1'b0;
    for (int b = 0; b < int'(NB); b++) begin
      BusBeatAck = 1'b0;
      repeat ((b == 4) ? 3 : 1) step();
      BusBeatAck = 1'b1;
      #1;
      obsAdr[b]  = BusAdr;
      obsData[b] = BusWData;
      step();
    end
    BusBeatAck = 1'b0;
    for (int b = 0; b < int'(NB); b++) begin
      chk($sformatf("stall_adr%0d", b), 64'(obsAdr[b]), 64'(32'h8000_1200 + 32'(8 * b)));
      chk($sformatf("stall_data%0d", b), obsData[b], 64'h1111_0000_0000_0000 + 64'(b));
    end
    step();
    chk("stall_idle_after", 64'(EvictReady), 64'd1);

    // Back-to-back: second line held valid during the first transfer
    EvictValid = 1'b1;
    EvictAdr   = 32'h8000_1234;
    EvictLine  = mkLine(64'h1111_0000_0000_0000);
    step();
    EvictAdr   = 32'h9000_0000;
    EvictLine  = mkLine(64'h2222_0000_0000_0000);
    BusBeatAck = 1'b1;
    repeat (NB) step();
    BusBeatAck = 1'b0;
    #1;
    chk("b2b_ready_gap", 64'(EvictReady), 64'd1);
    chk("b2b_write_gap", 64'(BusWrite), 64'd0);
    step();
    EvictValid = 1'b0;
    #1;
    chk("b2b_busy", 64'(Busy), 64'd1);
    chk("b2b_first_adr", 64'(BusAdr), 64'h9000_0000);
    chk("b2b_first_data", BusWData, 64'h2222_0000_0000_0000);
    drain();

    // Reset after the third ack abandons the line
    EvictValid = 1'b1;
    EvictAdr   = 32'h8000_1234;
    EvictLine  = mkLine(64'h1111_0000_0000_0000);
    step();
    EvictValid = 1'b0;
    BusBeatAck = 1'b1;
    repeat (3) step();
    BusBeatAck = 1'b0;
    reset = 1'b0;
    q.delete();
    #1;
    chk("midrst_BusWrite", 64'(BusWrite), 64'd0);
    chk("midrst_EvictReady", 64'(EvictReady), 64'd1);
    chk("midrst_Busy", 64'(Busy), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    step();
    EvictValid = 1'b1;
    EvictAdr   = 32'hA000_0040;
    EvictLine  = mkLine(64'h3333_0000_0000_0000);
    step();
    EvictValid = 1'b0;
    #1;
    chk("midrst_new_adr", 64'(BusAdr), 64'hA000_0040);
    chk("midrst_new_data", BusWData, 64'h3333_0000_0000_0000);
    drain();

    // Randomized traffic against the reference model
    for (int c = 0; c < 600; c++) begin
      EvictValid = ($urandom_range(0, 2) != 0);
      BusBeatAck = ($urandom_range(0, 3) != 0);
      EvictAdr   = $urandom();
      for (int w = 0; w < int'(LL / 32); w++) EvictLine[w*32 +: 32] = $urandom();
      case ($urandom_range(0, 2))
        0: LookupAdr = mLine | 32'($urandom_range(0, 63));
        1: LookupAdr = mLine + 32'h40;
        default: LookupAdr = $urandom();
      endcase
      step();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
